// File: rtl/gpr_file_param.sv
// gpr_file_param: parametrised register file with zero register, overflow register and post-reset clear sweep (optional GPR_BYPASS_EN write-first forwarding)
module gpr_file_param #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 5,
  parameter int          NUM_RD = 2,
  parameter int unsigned OF_REG = 30,
  parameter int unsigned OF_VAL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     of,
  output logic                     ready,
  output logic [ADDR_W-1:0]        clr_idx
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t                  r_state, w_state_nxt;
  logic [ADDR_W-1:0]       r_clr_idx;
  logic                    r_ready;
  logic [DATA_W-1:0]       r_mem [2**ADDR_W];
  logic [ADDR_W-1:0]       w_of_addr;
  logic [DATA_W-1:0]       w_of_val;
  assign w_of_addr = ADDR_W'(OF_REG);
  assign w_of_val  = DATA_W'(OF_VAL);
  assign ready     = r_ready;
  assign clr_idx   = r_clr_idx;
  if (OF_REG == 0) begin : g_of_reg_chk
    $error("gpr_file_param: OF_REG must not be 0");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_num_rd_chk
    $error("gpr_file_param: NUM_RD must be 1..4");
  end
  // sweep ends once the last entry has been cleared
  always_comb
    w_state_nxt = (r_state == CLEAR && r_clr_idx == '1) ? RUN : r_state;
  // state, sweep index and ready; reset restarts the sweep from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= (r_state == CLEAR) ? r_clr_idx + 1'b1 : '0;
      r_ready   <= (w_state_nxt == RUN);
    end
  end
  // storage: sweep clears in CLEAR; in RUN the overflow write is issued last so it wins on a collision
  always_ff @(posedge clk) begin
    if (!rst && r_state == CLEAR)
      r_mem[r_clr_idx] <= '0;
    else if (!rst && r_state == RUN) begin
      if (wr_en && wr_addr != '0)
        r_mem[wr_addr] <= wr_data;
      if (of)
        r_mem[w_of_addr] <= w_of_val;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    assign w_a = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef GPR_BYPASS_EN
    assign rd_data[k*DATA_W +: DATA_W] = (r_state != RUN || w_a == '0) ? '0 :
                                         (of && w_a == w_of_addr) ? w_of_val :
                                         (wr_en && w_a == wr_addr) ? wr_data : r_mem[w_a];
`else
    assign rd_data[k*DATA_W +: DATA_W] = (r_state != RUN || w_a == '0) ? '0 : r_mem[w_a];
`endif
  end
endmodule

// File: tb/tb_gpr_file_param.sv
// tb_gpr_file_param: directed and randomized checks of gpr_file_param against an array reference model
module tb_gpr_file_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        of = 1'b0;
  logic        ready;
  logic [4:0]  clr_idx;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m [32];
  bit run = 0;
  gpr_file_param dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .of(of), .ready(ready), .clr_idx(clr_idx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!run || a == 0) return 32'h0;
`ifdef GPR_BYPASS_EN
    if (of && a == 5'd30) return 32'h1;
    if (wr_en && a == wr_addr) return wr_data;
`endif
    return m[a];
  endfunction
  task automatic step();
    @(posedge clk);
    if (run && !rst) begin
      if (wr_en && wr_addr != 0) m[wr_addr] = wr_data;
      if (of) m[30] = 32'h1;
    end
    #1;
  endtask
  task automatic idle();
    wr_en = 0; of = 0; wr_addr = 0; wr_data = 0;
  endtask
  task automatic rd2(input string tag, input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
    chk({tag, "_p0"}, rd_data[31:0], exp_rd(a0));
    chk({tag, "_p1"}, rd_data[63:32], exp_rd(a1));
  endtask
  initial begin
    int cnt;
    step(); step();
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_clr_idx", {27'b0, clr_idx}, 32'h0);
    rd2("rst_rd", 5'd1, 5'd31);
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1; wr_addr = 5'($urandom_range(1, 31)); wr_data = $urandom; of = 1'($urandom);
      #1;
      chk("sweep_ready", {31'b0, ready}, 32'h0);
      chk("sweep_idx", {27'b0, clr_idx}, i);
      rd2("sweep_rd", 5'(i), 5'($urandom_range(1, 31)));
      step();
    end
    idle();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    run = 1;
    chk("sweep_done_ready", {31'b0, ready}, 32'h1);
    chk("sweep_done_idx", {27'b0, clr_idx}, 32'h0);
    rd2("after_sweep", 5'd4, 5'd30);
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; step(); idle();
    rd2("basic", 5'd5, 5'd0);
    chk("basic_r5", rd_data[31:0], 32'hDEADBEEF);
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; step(); idle();
    rd2("zero", 5'd0, 5'd0);
    chk("zero_r0", rd_data[63:32], 32'h0);
    wr_en = 1; wr_addr = 30; wr_data = 32'hFFFF0000; of = 1; step(); idle();
    rd2("of_prio", 5'd30, 5'd5);
    chk("of_prio_r30", rd_data[31:0], 32'h1);
    wr_en = 1; wr_addr = 3; wr_data = 7; of = 1; step(); idle();
    rd2("of_plus_wr", 5'd3, 5'd30);
    chk("of_plus_r3", rd_data[31:0], 32'h7);
    wr_en = 1; wr_addr = 9; wr_data = 32'hA; step();
    wr_data = 32'hB; rd_addr = {5'd0, 5'd9}; #1;
`ifdef GPR_BYPASS_EN
    chk("bypass_r9", rd_data[31:0], 32'hB);
`else
    chk("bypass_r9", rd_data[31:0], 32'hA);
`endif
    step(); idle();
    rd2("after_bypass", 5'd9, 5'd9);
    for (int i = 0; i < 300; i++) begin
      wr_en = 1'($urandom); wr_addr = 5'($urandom); wr_data = $urandom;
      of = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) wr_addr = 30;
      rd2("rand", 5'($urandom), ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom));
      step();
    end
    idle();
    rst = 1; step(); rst = 0; run = 0;
    wr_en = 1; wr_addr = 4; wr_data = 32'h55;
    for (int i = 0; i < 17; i++) step();
    chk("mid_idx17", {27'b0, clr_idx}, 32'd17);
    rst = 1; step(); rst = 0;
    chk("mid_rst_idx", {27'b0, clr_idx}, 32'h0);
    chk("mid_rst_ready", {31'b0, ready}, 32'h0);
    rd2("mid_rd", 5'd4, 5'd3);
    cnt = 0;
    while (!ready && cnt < 100) begin step(); cnt++; end
    chk("mid_sweep_len", cnt, 32'd32);
    idle();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    run = 1;
    rd2("dropped_r4", 5'd4, 5'd30);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
